// File: rtl/spi7001_tx.sv
// SPI7001 serial transmit engine: shifts words MSB-first with a generated SCLK and strobes LAT at frame end.
// Optional readback of the driver chain (spi_sdo -> rx_data) is enabled by defining SPI7001_TX_READBACK_EN.
module spi7001_tx #(
    parameter int DATA_W     = 16,
    parameter int LAT_CYCLES = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              spi_sclk,
    output logic              spi_sdi,
    output logic              spi_lat,
    output logic              busy,
    output logic              frame_done,
    input  logic              spi_sdo,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, SHIFT, WAIT, LATCH, GAP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              phase;
    logic              last_q;
    logic [DATA_W-2:0] shreg;   // bits still to send after the one on spi_sdi
    logic [7:0]        lat_cnt;
    logic [7:0]        gap_cnt;
    logic              eow;
    logic              accept;

    assign eow      = (state == SHIFT) && phase && (cnt == '0);
    assign in_ready = sys_rst_n && ((state == IDLE) || (state == WAIT) || (eow && !last_q));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            phase      <= 1'b0;
            last_q     <= 1'b0;
            shreg      <= '0;
            lat_cnt    <= '0;
            gap_cnt    <= '0;
            spi_sclk   <= 1'b0;
            spi_sdi    <= 1'b0;
            spi_lat    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                // Loading at end-of-word keeps the SCLK cadence unbroken
                state    <= SHIFT;
                shreg    <= in_data[DATA_W-2:0];
                last_q   <= in_last;
                cnt      <= CNT_W'(DATA_W - 1);
                phase    <= 1'b0;
                spi_sclk <= 1'b0;
                spi_sdi  <= in_data[DATA_W-1];
                busy     <= 1'b1;
            end else begin
                case (state)
                    SHIFT: begin
                        if (!phase) begin
                            phase    <= 1'b1;
                            spi_sclk <= 1'b1;
                        end else begin
                            spi_sclk <= 1'b0;
                            if (cnt != '0) begin
                                cnt     <= cnt - 1'b1;
                                phase   <= 1'b0;
                                spi_sdi <= shreg[DATA_W-2];
                                shreg   <= {shreg[DATA_W-3:0], 1'b0};
                            end else if (last_q) begin
                                state   <= LATCH;
                                spi_lat <= 1'b1;
                                lat_cnt <= 8'(LAT_CYCLES - 1);
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                    LATCH: begin
                        if (lat_cnt != '0) begin
                            lat_cnt <= lat_cnt - 1'b1;
                        end else begin
                            spi_lat    <= 1'b0;
                            spi_sdi    <= 1'b0;
                            frame_done <= 1'b1;
                            if (GAP_CYCLES == 0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= GAP;
                                gap_cnt <= 8'(GAP_CYCLES - 1);
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI7001_TX_READBACK_EN
    logic [DATA_W-2:0] rx_sh;

    // spi_sdo is taken while SCLK is high; the final bit goes straight into rx_data
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if ((state == SHIFT) && phase) begin
                rx_sh <= {rx_sh[DATA_W-3:0], spi_sdo};
                if (cnt == '0) begin
                    rx_data  <= {rx_sh, spi_sdo};
                    rx_valid <= 1'b1;
                end
            end
        end
    end
`else
    logic unused_sdo;
    assign unused_sdo = spi_sdo;
    assign rx_data    = '0;
    assign rx_valid   = 1'b0;
`endif

endmodule

// File: doc/spi7001_tx.md
# spi7001_tx

Serial transmit engine for the SPI7001 MiniLED driver chain. It runs in the ~1 MHz domain produced by the SPI7001 clock PLL. It accepts parallel words over a valid/ready handshake and shifts them MSB-first onto SDI with a generated SCLK. After the last word of a frame it pulses LAT to transfer the driver shift registers to their outputs. It sits between the frame/scan controller upstream and the driver pins downstream.

## Interface
Parameters:
- DATA_W, 16: bits per word.
- LAT_CYCLES, 2: clk cycles LAT is held high after a frame's last word (1..255).
- GAP_CYCLES, 4: idle clk cycles after LAT before the next word is accepted (0..255).

Ports:
- sys_clk  in  1  PLL divided clock (CLKOUTD); all logic on rising edge.
- sys_rst_n  in  1  synchronous, active-low reset.
- in_data  in  DATA_W  word to transmit.
- in_last  in  1  word is the final word of a frame.
- in_valid  in  1  in_data/in_last are valid.
- in_ready  out  1  block accepts a word this cycle.
- spi_sclk  out  1  serial clock to the driver.
- spi_sdi  out  1  serial data to the driver, changes only while spi_sclk=0.
- spi_lat  out  1  latch strobe.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the cycle LAT falls.
- spi_sdo  in  1  driver chain readback; used only with the macro below.
- rx_data  out  DATA_W  captured readback word; used only with the macro below.
- rx_valid  out  1  one-cycle pulse when rx_data updates; used only with the macro below.

## Operation
- States: IDLE, SHIFT, WAIT, LATCH, GAP.
- IDLE:
  - in_ready=1.
  - On in_valid, load the shift register, capture in_last, and move to SHIFT with bit counter = DATA_W-1 and phase=0.
- SHIFT: each bit occupies 2 cycles.
  - Phase 0: spi_sclk=0 and spi_sdi = current MSB.
  - Phase 1: spi_sclk=1 (driver samples on the rising edge), then shift left.
- End-of-word cycle (bit 0, phase 1), with in_last=0:
  - in_ready=1.
  - If in_valid, load the next word and continue in SHIFT with no gap.
  - Otherwise go to WAIT.
- End-of-word cycle with in_last=1: in_ready=0; go to LATCH.
- WAIT:
  - spi_sclk=0, spi_sdi holds, in_ready=1.
  - On in_valid, load the word and go to SHIFT. WAIT is unbounded.
- LATCH:
  - spi_lat=1 for exactly LAT_CYCLES cycles, spi_sclk=0, in_ready=0.
  - Then go to GAP, with frame_done=1 on the first GAP cycle (or the first IDLE cycle if GAP_CYCLES=0).
- GAP: all outputs idle and in_ready=0 for GAP_CYCLES cycles, then IDLE.
- in_valid outside an in_ready cycle is ignored. The upstream side must hold data until the handshake completes.
- Reset values: spi_sclk=0, spi_sdi=0, spi_lat=0, in_ready=0 while sys_rst_n=0, busy=0, frame_done=0, rx_data=0, rx_valid=0. The state is IDLE.
- Reset mid-operation aborts the word or frame on the next edge. No LAT is issued, and partial data is discarded.

## Timing
- Handshake at edge T (IDLE): the first SDI bit is visible from T+1 and the first SCLK rise is at T+2.
- One word = 2*DATA_W cycles (32 for default).
- Back-to-back words keep the SCLK period continuous, with exactly 2 cycles per bit.
- Frame end: the last SCLK high cycle is followed immediately by LAT_CYCLES cycles of LAT, then GAP_CYCLES cycles.
- Minimum frame overhead = LAT_CYCLES + GAP_CYCLES cycles.
- The bit counter is $clog2(DATA_W) bits wide and does not wrap mid-word.
- A handshake and reset in the same cycle: reset wins.

## Configuration
- SPI7001_TX_READBACK_EN defined:
  - spi_sdo is sampled on each phase-1 cycle, at the rising SCLK, into an rx shift register MSB-first.
  - On the end-of-word cycle, rx_data takes the full word and rx_valid pulses for 1 cycle.
- Undefined: spi_sdo is ignored, rx_data=0 and rx_valid=0 constantly, and no rx registers are inferred.

## Test plan
- Single word 16'hA5F0 with in_last=1 → SDI sequence 1010_0101_1111_0000 on 16 SCLK rises, LAT high 2 cycles, frame_done pulse, busy low after 4 GAP cycles.
- Two words 16'h0001 (last=0) then 16'h8000 (last=1), offered continuously → 32 uninterrupted SCLK pulses and a single LAT after the 32nd rise.
- Word 16'hFFFF (last=0), then in_valid withheld for 10 cycles → WAIT with SCLK=0 and in_ready=1; the next word 16'h1234 (last=1) resumes shifting at the following edge.
- Reset asserted at bit 7 of word 16'h5555 → next edge: SCLK=0, SDI=0, LAT never asserted, in_ready=0 during reset, 1 after release.
- in_valid held high during LATCH/GAP → no acceptance until IDLE; the word is then sent intact.
- With SPI7001_TX_READBACK_EN defined, spi_sdo driven with 16'hC3C3 → rx_data=16'hC3C3 and rx_valid pulses once at end of word.
